ddr_app_responder: RTL and testbench

//  Responder end of the MIG-style DDR2 user (app_*) interface. It accepts app commands and write-data beats,

---
 rtl/ddr_app_pkg.sv | 35 +++
 rtl/synchronous_buffer.sv | 52 +++++
 rtl/ddr_app_responder.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ddr_app_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_app_pkg.sv
// Shared types for the DDR app-interface responder: command/beat records and exec FSM states.
package ddr_app_pkg;

  localparam int APP_BURST_W = 12;
  localparam int APP_DATA_W  = 64;
  localparam int APP_MASK_W  = 8;

  typedef enum logic [2:0] {
    APP_WRITE = 3'b000,
    APP_READ  = 3'b001
  } app_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    WR0,
    WR1,
    RD0,
    RD1
  } app_exec_t;

  typedef struct packed {
    app_cmd_t               cmd;
    logic [APP_BURST_W-1:0] burst;
  } app_command_t;

  typedef struct packed {
    logic [APP_DATA_W-1:0] data;
    logic [APP_MASK_W-1:0] mask;
  } app_wbeat_t;

  function automatic logic is_legal_cmd(input logic [2:0] c);
    return (c == APP_WRITE) || (c == APP_READ);
  endfunction

endpackage

// File: rtl/synchronous_buffer.sv
// Generic single-clock first-word-fall-through FIFO with full/empty/count.
module synchronous_buffer #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  push;
  logic                  pop;

  assign full_o    = (count_reg == CW'(DEPTH));
  assign empty_o   = (count_reg == '0);
  assign count_o   = count_reg;
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem[rd_ptr_reg];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= wr_data_i;
  end

endmodule

// File: rtl/ddr_app_responder.sv
// Simulation/FPGA stand-in for a MIG DDR2 controller: queues app commands and write beats,
// stores 128-bit bursts in on-chip RAM and returns reads as two 64-bit beats.
module ddr_app_responder
  import ddr_app_pkg::*;
#(
  parameter int ADDR_WIDTH       = 27,
  parameter int MEM_DEPTH_LOG2   = APP_BURST_W,
  parameter int CMD_FIFO_DEPTH   = 4,
  parameter int READ_LATENCY     = 4,
  parameter int CALIB_CYCLES     = 64,
  parameter int RDY_STALL_PERIOD = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] app_addr_i,
  input  logic [2:0]            app_cmd_i,
  input  logic                  app_en_i,
  output logic                  app_rdy_o,
  input  logic [63:0]           app_wdf_data_i,
  input  logic [7:0]            app_wdf_mask_i,
  input  logic                  app_wdf_wren_i,
  input  logic                  app_wdf_end_i,
  output logic                  app_wdf_rdy_o,
  output logic [63:0]           app_rd_data_o,
  output logic                  app_rd_data_valid_o,
  output logic                  app_rd_data_end_o,
  output logic                  init_calib_complete_o,
  output logic                  error_o
);

  localparam int CMD_LOG2 = $clog2(CMD_FIFO_DEPTH);
  localparam int WDF_LOG2 = CMD_LOG2 + 1;
  localparam int CMD_W    = $bits(app_command_t);
  localparam int WBEAT_W  = $bits(app_wbeat_t);
  localparam int CAL_W    = $clog2(CALIB_CYCLES + 1);

  // ---------------- calibration and ready ----------------
  logic [CAL_W-1:0] cal_cnt_reg;
  logic             calib;
  logic             stall;
  logic             cmd_full;
  logic             wdf_full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                 cal_cnt_reg <= '0;
    else if (cal_cnt_reg != CAL_W'(CALIB_CYCLES)) cal_cnt_reg <= cal_cnt_reg + CAL_W'(1);
  end

  assign calib                 = (cal_cnt_reg == CAL_W'(CALIB_CYCLES));
  assign init_calib_complete_o = calib;
  assign app_rdy_o             = calib && !cmd_full && !stall;
  assign app_wdf_rdy_o         = calib && !wdf_full;

  generate
    if (RDY_STALL_PERIOD > 0) begin : g_stall
      localparam int SW = $clog2(RDY_STALL_PERIOD + 1);
      logic [SW-1:0] stall_cnt_reg;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      stall_cnt_reg <= '0;
        else if (stall) stall_cnt_reg <= '0;
        else            stall_cnt_reg <= stall_cnt_reg + SW'(1);
      end
      assign stall = (stall_cnt_reg == SW'(RDY_STALL_PERIOD - 1));
    end else begin : g_no_stall
      assign stall = 1'b0;
    end
  endgenerate

  // ---------------- command and write-data queues ----------------
  app_command_t       cmd_in;
  app_command_t       cmd_head;
  app_wbeat_t         wbeat_in;
  app_wbeat_t         wbeat_head;
  logic [CMD_W-1:0]   cmd_rd_data;
  logic [WBEAT_W-1:0] wdf_rd_data;
  logic               cmd_push;
  logic               wdf_push;
  logic               cmd_pop;
  logic               wdf_pop;
  logic               cmd_empty;
  logic [WDF_LOG2:0]  wdf_count;
  logic [CMD_LOG2:0]  cmd_count_unused;
  logic               wdf_empty_unused;
  logic               unused_addr;

  assign cmd_push       = app_en_i && app_rdy_o;
  assign wdf_push       = app_wdf_wren_i && app_wdf_rdy_o;
  assign cmd_in.cmd     = app_cmd_t'(app_cmd_i);
  assign cmd_in.burst   = APP_BURST_W'(app_addr_i[3 +: MEM_DEPTH_LOG2]);
  assign wbeat_in.data  = app_wdf_data_i;
  assign wbeat_in.mask  = app_wdf_mask_i;
  assign cmd_head       = cmd_rd_data;
  assign wbeat_head     = wdf_rd_data;
  // Sub-burst offset is ignored and upper address bits alias onto the stored bursts.
  assign unused_addr    = ^{app_addr_i[2:0], app_addr_i[ADDR_WIDTH-1:3+MEM_DEPTH_LOG2]};

  synchronous_buffer #(.WIDTH(CMD_W), .DEPTH_LOG2(CMD_LOG2)) u_cmd_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (cmd_push),
    .wr_data_i (cmd_in),
    .rd_en_i   (cmd_pop),
    .rd_data_o (cmd_rd_data),
    .full_o    (cmd_full),
    .empty_o   (cmd_empty),
    .count_o   (cmd_count_unused)
  );

  synchronous_buffer #(.WIDTH(WBEAT_W), .DEPTH_LOG2(WDF_LOG2)) u_wdf_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wdf_push),
    .wr_data_i (wbeat_in),
    .rd_en_i   (wdf_pop),
    .rd_data_o (wdf_rd_data),
    .full_o    (wdf_full),
    .empty_o   (wdf_empty_unused),
    .count_o   (wdf_count)
  );

  // ---------------- exec FSM ----------------
  app_exec_t state_reg;
  app_exec_t state_next;
  logic      ram_we0;
  logic      ram_we1;
  logic      rd_req;
  logic      rd_end;
  logic      illegal_pop;
  logic      head_legal;

  assign head_legal = is_legal_cmd(cmd_head.cmd);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!cmd_empty) begin
          if (cmd_head.cmd == APP_WRITE && wdf_count >= (WDF_LOG2+1)'(2)) state_next = WR0;
          else if (cmd_head.cmd == APP_READ)                              state_next = RD0;
        end
      end
      WR0:     state_next = WR1;
      RD0:     state_next = RD1;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_pop     = 1'b0;
    wdf_pop     = 1'b0;
    ram_we0     = 1'b0;
    ram_we1     = 1'b0;
    rd_req      = 1'b0;
    rd_end      = 1'b0;
    illegal_pop = 1'b0;
    case (state_reg)
      IDLE: begin
        illegal_pop = !cmd_empty && !head_legal;
        cmd_pop     = illegal_pop;
      end
      WR0: begin
        ram_we0 = 1'b1;
        wdf_pop = 1'b1;
      end
      WR1: begin
        ram_we1 = 1'b1;
        wdf_pop = 1'b1;
        cmd_pop = 1'b1;
      end
      RD0: rd_req = 1'b1;
      RD1: begin
        rd_req  = 1'b1;
        rd_end  = 1'b1;
        cmd_pop = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- protocol error tracking ----------------
  logic beat_par_reg;
  logic error_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_par_reg <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      if (wdf_push) beat_par_reg <= !beat_par_reg;
      if ((cmd_push && !is_legal_cmd(app_cmd_i)) ||
          (wdf_push && (app_wdf_end_i != beat_par_reg)) ||
          illegal_pop)
        error_reg <= 1'b1;
    end
  end

  assign error_o = error_reg;

  // ---------------- burst RAM (contents survive reset) ----------------
  logic [63:0]               mem0 [2**MEM_DEPTH_LOG2];
  logic [63:0]               mem1 [2**MEM_DEPTH_LOG2];
  logic [63:0]               ram_q0;
  logic [63:0]               ram_q1;
  logic [MEM_DEPTH_LOG2-1:0] ram_idx;

  assign ram_idx = cmd_head.burst[MEM_DEPTH_LOG2-1:0];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 8; b++) begin
      if (ram_we0 && !wbeat_head.mask[b]) mem0[ram_idx][b*8 +: 8] <= wbeat_head.data[b*8 +: 8];
      if (ram_we1 && !wbeat_head.mask[b]) mem1[ram_idx][b*8 +: 8] <= wbeat_head.data[b*8 +: 8];
    end
    ram_q0 <= mem0[ram_idx];
    ram_q1 <= mem1[ram_idx];
  end

  // ---------------- read return pipeline ----------------
  logic        s0_valid_reg;
  logic        s0_end_reg;
  logic [63:0] s0_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s0_valid_reg <= 1'b0;
      s0_end_reg   <= 1'b0;
    end else begin
      s0_valid_reg <= rd_req;
      s0_end_reg   <= rd_end;
    end
  end

  // The RAM output register is not reset, so gate it until a real beat is present.
  assign s0_data = !s0_valid_reg ? 64'd0 : (s0_end_reg ? ram_q1 : ram_q0);

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign app_rd_data_valid_o = s0_valid_reg;
      assign app_rd_data_end_o   = s0_end_reg;
      assign app_rd_data_o       = s0_data;
    end else begin : g_latn
      logic [READ_LATENCY-2:0] vld_reg;
      logic [READ_LATENCY-2:0] end_reg;
      logic [63:0]             dat_reg [READ_LATENCY-1];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          vld_reg <= '0;
          end_reg <= '0;
          for (int i = 0; i < READ_LATENCY-1; i++) dat_reg[i] <= '0;
        end else begin
          vld_reg[0] <= s0_valid_reg;
          end_reg[0] <= s0_end_reg;
          dat_reg[0] <= s0_data;
          for (int i = 1; i < READ_LATENCY-1; i++) begin
            vld_reg[i] <= vld_reg[i-1];
            end_reg[i] <= end_reg[i-1];
            dat_reg[i] <= dat_reg[i-1];
          end
        end
      end

      assign app_rd_data_valid_o = vld_reg[READ_LATENCY-2];
      assign app_rd_data_end_o   = end_reg[READ_LATENCY-2];
      assign app_rd_data_o       = dat_reg[READ_LATENCY-2];
    end
  endgenerate

endmodule

// File: tb/tb_ddr_app_responder.sv
// Directed bench for ddr_app_responder: calibration, masked writes, ordering, protocol errors, reset.
module tb_ddr_app_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [26:0] app_addr = '0;
  logic [2:0]  app_cmd = '0;
  logic        app_en = 1'b0;
  logic        app_rdy;
  logic [63:0] wdf_data = '0;
  logic [7:0]  wdf_mask = '0;
  logic        wdf_wren = 1'b0;
  logic        wdf_end = 1'b0;
  logic        wdf_rdy;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        rd_end;
  logic        calib;
  logic        err;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] DA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] DM = 64'hAAAA_AAAA_1111_1111;
  localparam logic [63:0] D3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] D5 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] D6 = 64'h6666_6666_6666_6666;
  localparam logic [63:0] D70 = 64'h7070_7070_7070_7070;
  localparam logic [63:0] D71 = 64'h7171_7171_7171_7171;

  always #5 clk = ~clk;

  ddr_app_responder dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .app_addr_i            (app_addr),
    .app_cmd_i             (app_cmd),
    .app_en_i              (app_en),
    .app_rdy_o             (app_rdy),
    .app_wdf_data_i        (wdf_data),
    .app_wdf_mask_i        (wdf_mask),
    .app_wdf_wren_i        (wdf_wren),
    .app_wdf_end_i         (wdf_end),
    .app_wdf_rdy_o         (wdf_rdy),
    .app_rd_data_o         (rd_data),
    .app_rd_data_valid_o   (rd_valid),
    .app_rd_data_end_o     (rd_end),
    .init_calib_complete_o (calib),
    .error_o               (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_burst(input logic [26:0] a, input logic [63:0] d0, input logic [7:0] m0,
                          input logic [63:0] d1, input logic [7:0] m1);
    app_en = 1'b1; app_cmd = 3'b000; app_addr = a;
    wdf_wren = 1'b1; wdf_data = d0; wdf_mask = m0; wdf_end = 1'b0;
    tick();
    app_en = 1'b0;
    wdf_data = d1; wdf_mask = m1; wdf_end = 1'b1;
    tick();
    wdf_wren = 1'b0; wdf_end = 1'b0;
    $display("wr addr=%h d0=%h m0=%h d1=%h m1=%h", a, d0, m0, d1, m1);
  endtask

  task automatic rd_cmd(input logic [26:0] a);
    app_en = 1'b1; app_cmd = 3'b001; app_addr = a;
    tick();
    app_en = 1'b0;
    $display("rd addr=%h", a);
  endtask

  // Bounded wait for the next beat0, then check both beats of the burst.
  task automatic expect_burst(input string tag, input logic [63:0] e0, input logic [63:0] e1);
    int n = 0;
    while (!rd_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid0"}, rd_valid, 1);
    chk({tag, "_beat0"}, rd_data, e0);
    chk({tag, "_end0"}, rd_end, 0);
    tick();
    chk({tag, "_valid1"}, rd_valid, 1);
    chk({tag, "_beat1"}, rd_data, e1);
    chk({tag, "_end1"}, rd_end, 1);
    tick();
  endtask

  logic [63:0] exp_beats [8];
  logic [63:0] got_beats [8];
  logic        got_ends  [8];
  int          nbeats;
  int          nvalid;
  logic        accepted;

  initial begin
    // 1. reset and calibration
    tick(); tick();
    chk("rst_calib", calib, 0);
    chk("rst_rdy", app_rdy, 0);
    chk("rst_wdf_rdy", wdf_rdy, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_error", err, 0);
    rst = 1'b0;
    repeat (63) tick();
    chk("cal63_calib", calib, 0);
    chk("cal63_rdy", app_rdy, 0);
    chk("cal63_wdf_rdy", wdf_rdy, 0);
    tick();
    chk("cal64_calib", calib, 1);
    chk("cal64_rdy", app_rdy, 1);
    chk("cal64_wdf_rdy", wdf_rdy, 1);

    // 2. write burst then read with exact latency
    wr_burst(27'h10, D1, 8'h00, D2, 8'h00);
    repeat (5) tick();
    rd_cmd(27'h10);
    repeat (4) tick();
    chk("lat_t4_valid", rd_valid, 0);
    tick();
    chk("lat_t5_valid", rd_valid, 1);
    chk("lat_t5_data", rd_data, D1);
    chk("lat_t5_end", rd_end, 0);
    tick();
    chk("lat_t6_valid", rd_valid, 1);
    chk("lat_t6_data", rd_data, D2);
    chk("lat_t6_end", rd_end, 1);
    tick();
    chk("lat_t7_valid", rd_valid, 0);

    // 3. masked write, read issued right behind it
    wr_burst(27'h10, DA, 8'h0F, D3, 8'hFF);
    rd_cmd(27'h10);
    expect_burst("mask", DM, D2);

    // 4. queue fills: blocked write plus three reads, fourth read waits
    app_en = 1'b1; app_cmd = 3'b000; app_addr = 27'h38;
    tick();
    app_cmd = 3'b001;
    tick();
    app_addr = 27'h10;
    tick();
    app_addr = 27'h38;
    tick();
    chk("full_rdy", app_rdy, 0);
    app_addr = 27'h10;
    tick(); tick();
    chk("full_rdy_held", app_rdy, 0);
    wdf_wren = 1'b1; wdf_data = D70; wdf_mask = 8'h00; wdf_end = 1'b0;
    tick();
    wdf_data = D71; wdf_end = 1'b1;
    tick();
    wdf_wren = 1'b0; wdf_end = 1'b0;
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (app_rdy) begin
        tick();
        accepted = 1'b1;
        break;
      end
      tick();
    end
    app_en = 1'b0;
    chk("rd4_accept", accepted, 1);
    exp_beats = '{D70, D71, DM, D2, D70, D71, DM, D2};
    nbeats = 0;
    for (int c = 0; c < 100 && nbeats < 8; c++) begin
      if (rd_valid) begin
        got_beats[nbeats] = rd_data;
        got_ends[nbeats]  = rd_end;
        $display("beat %0d data=%h end=%0b", nbeats, rd_data, rd_end);
        nbeats++;
      end
      tick();
    end
    chk("b2b_count", nbeats, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_data%0d", i), got_beats[i], exp_beats[i]);
      chk($sformatf("b2b_end%0d", i), got_ends[i], i % 2);
    end
    chk("b2b_no_error", err, 0);

    // 5. early write data, illegal command
    wdf_wren = 1'b1; wdf_data = D5; wdf_mask = 8'h00; wdf_end = 1'b0;
    tick();
    wdf_data = D6; wdf_end = 1'b1;
    tick();
    wdf_wren = 1'b0; wdf_end = 1'b0;
    tick(); tick();
    app_en = 1'b1; app_cmd = 3'b000; app_addr = 27'h48;
    tick();
    app_en = 1'b0;
    chk("early_no_error", err, 0);
    app_en = 1'b1; app_cmd = 3'b010; app_addr = 27'h0;
    tick();
    app_en = 1'b0;
    chk("illegal_cmd_error", err, 1);
    rd_cmd(27'h48);
    expect_burst("early", D5, D6);
    chk("error_sticky", err, 1);
    repeat (3) tick();

    // 6. reset during RD1
    rd_cmd(27'h10);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("midrst_valid", rd_valid, 0);
    chk("midrst_data", rd_data, 0);
    chk("midrst_end", rd_end, 0);
    chk("midrst_calib", calib, 0);
    chk("midrst_rdy", app_rdy, 0);
    chk("midrst_error", err, 0);
    tick(); tick();
    rst = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 12; c++) begin
      if (rd_valid) nvalid++;
      tick();
    end
    chk("postrst_no_beats", nvalid, 0);
    repeat (60) tick();
    chk("recal_calib", calib, 1);
    rd_cmd(27'h38);
    expect_burst("retain38", D70, D71);
    rd_cmd(27'h10);
    expect_burst("retain10", DM, D2);
    chk("recal_no_error", err, 0);

    // end flag must start at 0 after reset
    wdf_wren = 1'b1; wdf_data = D3; wdf_mask = 8'h00; wdf_end = 1'b1;
    tick();
    wdf_wren = 1'b0; wdf_end = 1'b0;
    chk("parity_error", err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
